// File: rtl/regfile.sv
// LEGv8 architectural register file: 32 x 64-bit registers with one synchronous
// write port and two combinational read ports. X[ZERO_REG] always reads zero
// and ignores writes. BYPASS=1 forwards a same-cycle write to matching reads.
module regfile #(
    parameter bit          BYPASS   = 1'b1,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [4:0]  WriteRegister,
    input  logic [63:0] WriteData,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    output logic [63:0] ReadData1,
    output logic [63:0] ReadData2
);

    localparam logic [4:0] ZERO_IDX = ZERO_REG[4:0];

    logic [63:0] regs_q [32];
    logic [31:0] wr_en_d;
    logic        wr_live;

    // A write is live only when enabled, out of reset, and not aimed at the zero register.
    assign wr_live = RegWrite && !reset && (WriteRegister != ZERO_IDX);

    // 5:32 write decoder producing one-hot per-register load enables.
    always_comb begin
        // NOTE: default assigned first so every path drives wr_en_d and no latch is inferred.
        wr_en_d = '0;
        if (wr_live) begin
            wr_en_d[WriteRegister] = 1'b1;
        end
    end

    // Register array: synchronous clear dominates; otherwise each register loads or holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the storage is explicitly cleared because the core relies on all registers reading 0 after reset.
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (wr_en_d[i]) begin
                    // NOTE: non-blocking so every register samples the pre-edge values consistently.
                    regs_q[i] <= WriteData;
                end
            end
        end
    end

    // Read port 1: zero-register mask, optional bypass, then 32:1 select.
    always_comb begin
        ReadData1 = regs_q[ReadRegister1];
        if (ReadRegister1 == ZERO_IDX) begin
            ReadData1 = '0;
        end else if (BYPASS && wr_live && (WriteRegister == ReadRegister1)) begin
            ReadData1 = WriteData;
        end
    end

    // Read port 2: same structure as port 1, independent select.
    always_comb begin
        ReadData2 = regs_q[ReadRegister2];
        if (ReadRegister2 == ZERO_IDX) begin
            ReadData2 = '0;
        end else if (BYPASS && wr_live && (WriteRegister == ReadRegister2)) begin
            ReadData2 = WriteData;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: one instance with bypass, one without, driven
// in parallel. Expected read data is pushed to a scoreboard queue when stimulus
// is applied and popped/compared once the read path has settled.
module tb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] rd1_byp, rd2_byp, rd1_nob, rd2_nob;

    always #5 clk = ~clk;

    regfile #(.BYPASS(1'b1), .ZERO_REG(31)) dut_byp (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_byp), .ReadData2(rd2_byp)
    );

    regfile #(.BYPASS(1'b0), .ZERO_REG(31)) dut_nob (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_nob), .ReadData2(rd2_nob)
    );

    typedef struct {
        string       tag;
        int          sel;   // 0: byp port1, 1: byp port2, 2: nob port1, 3: nob port2
        logic [63:0] exp;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    logic [63:0] mdl [32];
    int          n_cmp = 0;
    int          n_bad = 0;

    localparam logic [63:0] BASE = 64'h0123_4567_89AB_CDE0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference read behaviour, evaluated against the pre-edge model state.
    function automatic logic [63:0] exp_read(input bit byp, input bit rst, input bit we,
                                             input logic [4:0] wa, input logic [63:0] wd,
                                             input logic [4:0] ra);
        if (ra == 5'd31) return 64'h0;
        if (byp && we && !rst && (wa == ra)) return wd;
        return mdl[ra];
    endfunction

    // One clock cycle: drive at negedge, queue expectations, compare after settle, update model at posedge.
    task automatic step(input string tag, input bit rst, input bit we, input logic [4:0] wa,
                        input logic [63:0] wd, input logic [4:0] ra1, input logic [4:0] ra2,
                        input bit chk);
        sb_entry_t e;
        @(negedge clk);
        reset = rst; RegWrite = we; WriteRegister = wa; WriteData = wd;
        ReadRegister1 = ra1; ReadRegister2 = ra2;
        if (chk) begin
            e.tag = {tag, "/byp_rd1"}; e.sel = 0; e.exp = exp_read(1'b1, rst, we, wa, wd, ra1); sb_q.push_back(e);
            e.tag = {tag, "/byp_rd2"}; e.sel = 1; e.exp = exp_read(1'b1, rst, we, wa, wd, ra2); sb_q.push_back(e);
            e.tag = {tag, "/nob_rd1"}; e.sel = 2; e.exp = exp_read(1'b0, rst, we, wa, wd, ra1); sb_q.push_back(e);
            e.tag = {tag, "/nob_rd2"}; e.sel = 3; e.exp = exp_read(1'b0, rst, we, wa, wd, ra2); sb_q.push_back(e);
        end
        #3;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                0:       check(e.tag, rd1_byp, e.exp);
                1:       check(e.tag, rd2_byp, e.exp);
                2:       check(e.tag, rd1_nob, e.exp);
                default: check(e.tag, rd2_nob, e.exp);
            endcase
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
        end else if (we && wa != 5'd31) begin
            mdl[wa] = wd;
        end
    endtask

    initial begin
        reset = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        for (int i = 0; i < 32; i++) mdl[i] = 'x;

        // Zero register reads 0 even before any reset.
        step("prereset_zero", 1'b0, 1'b0, 5'd0, 64'h0, 5'd31, 5'd31, 1'b0);
        check("prereset_zero_rd1", rd1_byp, 64'h0);

        // Reset, then sweep both ports over all indices.
        step("reset", 1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 32; i++)
            step("reset_sweep", 1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i), 1'b1);

        // Write k+BASE to register k; port 1 watches the register being written.
        for (int k = 0; k < 31; k++)
            step("write", 1'b0, 1'b1, 5'(k), BASE + 64'(k), 5'(k), 5'((k + 31) % 32), 1'b1);
        for (int i = 0; i < 32; i++)
            step("readback", 1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i), 1'b1);

        // Zero register ignores writes; neighbours untouched.
        step("zero_wr", 1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd30, 1'b1);
        step("zero_rd", 1'b0, 1'b0, 5'd0, 64'h0, 5'd31, 5'd30, 1'b1);

        // Write disabled keeps the old value.
        step("wr_dis", 1'b0, 1'b0, 5'd5, 64'hDEAD_BEEF, 5'd5, 5'd5, 1'b1);
        step("wr_dis_rd", 1'b0, 1'b0, 5'd0, 64'h0, 5'd5, 5'd4, 1'b1);

        // Bypass: reg 7 = 0x11, then write 0x22 while both ports read 7.
        step("byp_setup", 1'b0, 1'b1, 5'd7, 64'h11, 5'd0, 5'd1, 1'b1);
        step("byp_same", 1'b0, 1'b1, 5'd7, 64'h22, 5'd7, 5'd7, 1'b1);
        step("byp_after", 1'b0, 1'b0, 5'd0, 64'h0, 5'd7, 5'd7, 1'b1);

        // Back-to-back writes to the same register.
        step("b2b_1", 1'b0, 1'b1, 5'd9, 64'h1, 5'd9, 5'd9, 1'b1);
        step("b2b_2", 1'b0, 1'b1, 5'd9, 64'h2, 5'd9, 5'd9, 1'b1);
        step("b2b_rd", 1'b0, 1'b0, 5'd0, 64'h0, 5'd9, 5'd9, 1'b1);

        // Reset beats a concurrent write; the write lands on the next edge.
        step("rst_wr", 1'b1, 1'b1, 5'd3, 64'hAA, 5'd3, 5'd7, 1'b1);
        step("rst_wr_after", 1'b0, 1'b1, 5'd3, 64'hAA, 5'd3, 5'd7, 1'b1);
        step("rst_wr_rd", 1'b0, 1'b0, 5'd0, 64'h0, 5'd3, 5'd9, 1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 60; n++)
            step("rand", 1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 {$urandom, $urandom}, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1);

        check("sb_drain", 64'(sb_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile.md
# regfile

Architectural register file for the LEGv8 datapath: 32 registers × 64 bits with one synchronous write port and two combinational read ports. The block holds the state that the 32:1 read-select muxes choose from, so it sits directly upstream of operand read. Each read port drives the decode-stage operand buses. X31 (XZR) is hardwired to zero. An optional same-cycle write-to-read bypass removes write-back/decode hazards in the pipelined core.

## Interface

Parameters:
- BYPASS, default 1: 1 = a read that hits the register being written this cycle returns WriteData; 0 = it returns the stored (old) value.
- ZERO_REG, default 31: register index that always reads 0 and ignores writes.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all 32 registers on the rising edge where it is 1.
- RegWrite  input  1  write enable for the current cycle.
- WriteRegister  input  5  destination register index.
- WriteData  input  64  value written at the next rising edge.
- ReadRegister1  input  5  read port 1 index.
- ReadRegister2  input  5  read port 2 index.
- ReadData1  output  64  contents of ReadRegister1.
- ReadData2  output  64  contents of ReadRegister2.

## Operation

- Storage is 32 × 64-bit registers, each built from D flip-flops with an enable (hold/load mux in front of each DFF).
- Write decode: a 5:32 decoder, gated by RegWrite, produces one-hot per-register enables. At most one enable is active per cycle. The enable for ZERO_REG is forced to 0.
- Write: at a rising edge with reset=0, RegWrite=1 and WriteRegister≠ZERO_REG, reg[WriteRegister] ← WriteData. All other registers hold.
- Reset: at a rising edge with reset=1, all registers ← 64'h0. Reset dominates RegWrite; a write presented in a reset cycle is dropped.
- Read: each port has its own 64-bit 32:1 select on the register array. The index equal to ZERO_REG returns 64'h0 regardless of stored contents.
- Bypass (BYPASS=1): if RegWrite=1, reset=0, WriteRegister==ReadRegisterN and WriteRegister≠ZERO_REG, then ReadDataN = WriteData in the same cycle. Both ports bypass independently, and both may hit the same register at once.
- Bypass (BYPASS=0): reads return the stored value only. The new value is visible from the cycle after the write edge.
- Both read ports may address the same register; both return identical data.

## Timing

- Read latency: 0 cycles. ReadData1/2 are combinational from ReadRegister1/2, the register array, and the bypass terms (when BYPASS=1).
- Write latency: 1 edge. Data captured at the rising edge; visible on non-bypassed reads after that edge plus the read-path delay.
- Read path is gate-level. At 50 ps per gate, the worst-case read settle is ≤ 600 ps: the select tree plus bypass mux. Benches sample outputs no earlier than that after any input change.
- Reset values: every register is 0 after the first reset edge. ReadData1 and ReadData2 are 0 for any index following that edge, with RegWrite=0.
- Before the first reset, register contents are X, except that ZERO_REG reads 0.
- Reset asserted mid-sequence: registers clear at that edge. Writes resume on the first edge with reset=0.
- Back-to-back writes to the same register on consecutive edges: the last write wins. With no bypass, each read observes the value from the previous edge.

## Test plan

- Reset then read all: assert reset for 1 edge, then sweep ReadRegister1 and ReadRegister2 over 0–31 -> both read 64'h0 for every index.
- Write/readback: for k = 0–30, write 64'h0123_4567_89AB_CDE0 + k to register k on successive edges, then sweep both read ports -> each reads its written value. Register 31 reads 0.
- Zero register: RegWrite=1, WriteRegister=31, WriteData=64'hFFFF_FFFF_FFFF_FFFF for 1 edge -> ReadData1 with ReadRegister1=31 stays 64'h0. No other register changes.
- Write disabled: RegWrite=0, WriteRegister=5, WriteData=64'hDEAD_BEEF -> register 5 keeps its prior value after the edge.
- Bypass: BYPASS=1, reg 7 = 64'h11. Same cycle: RegWrite=1, WriteRegister=7, WriteData=64'h22, ReadRegister1=ReadRegister2=7 -> both ports read 64'h22 before the edge and after it. With BYPASS=0, both ports read 64'h11 before the edge and 64'h22 after it.
- Reset beats write: reset=1 and RegWrite=1 to register 3 with 64'hAA in the same cycle -> register 3 reads 64'h0 after the edge. With reset=0 on the next edge, the same write lands, and register 3 reads 64'hAA.
